// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between the instruction-fetch requester
//   and the data load/store requester. Data has fixed priority. A fetch is
//   forced after STARVE_LIMIT consecutive data wins over a pending fetch.
//   Each transaction is a req/ack handshake. It aborts with an error after
//   MAX_WAIT busy cycles that see no ack.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   if_req/if_addr           fetch request (held until if_gnt)
//   if_gnt                   fetch accepted (combinational, IDLE only)
//   if_valid/if_rdata/if_err fetch completion pulse, word, timeout flag
//   d_req/d_we/d_size/d_unsigned/d_addr/d_wdata   data request fields
//   d_gnt                    data accepted (combinational, IDLE only)
//   d_valid/d_rdata/d_err    data completion pulse, load word, timeout flag
//   mem_req..mem_wdata       memory request, driven from latched fields
//   mem_ack/mem_rdata        memory completion and read data
//   owner                    0 = fetch, 1 = data (current/last grant)
module mem_port_arbiter #(
    parameter int MAX_WAIT     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        owner
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} stateT;

    stateT          state;
    logic [WW-1:0]  waitCnt;
    logic [SW-1:0]  starveCnt;

    wire starveHit = (starveCnt == STARVE_MAX);

    // Grants are gated by rst so nothing looks accepted during a reset cycle.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst && state == IDLE) begin
            if (d_req && !(if_req && starveHit))
                d_gnt = 1'b1;
            else if (if_req)
                if_gnt = 1'b1;
        end
    end

    assign mem_req = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            waitCnt      <= '0;
            starveCnt    <= '0;
            owner        <= 1'b0;
            mem_we       <= 1'b0;
            mem_size     <= 2'b00;
            mem_unsigned <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_valid     <= 1'b0;
            if_rdata     <= '0;
            if_err       <= 1'b0;
            d_valid      <= 1'b0;
            d_rdata      <= '0;
            d_err        <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    // A mem_ack arriving here belongs to an aborted access.
                    // It is dropped.
                    if (d_gnt) begin
                        state        <= BUSY_D;
                        owner        <= 1'b1;
                        waitCnt      <= '0;
                        mem_we       <= d_we;
                        mem_size     <= d_size;
                        mem_unsigned <= d_unsigned;
                        mem_addr     <= d_addr;
                        mem_wdata    <= d_wdata;
                        if (if_req && !starveHit)
                            starveCnt <= starveCnt + SW'(1);
                    end else if (if_gnt) begin
                        state        <= BUSY_IF;
                        owner        <= 1'b0;
                        waitCnt      <= '0;
                        mem_we       <= 1'b0;
                        mem_size     <= 2'b00;
                        mem_unsigned <= 1'b0;
                        mem_addr     <= if_addr;
                        mem_wdata    <= '0;
                        starveCnt    <= '0;
                    end
                end
                BUSY_IF, BUSY_D: begin
                    if (mem_ack) begin
                        state <= IDLE;
                        if (state == BUSY_IF) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                            if_err   <= 1'b0;
                        end else begin
                            d_valid <= 1'b1;
                            d_rdata <= mem_we ? 32'd0 : mem_rdata;
                            d_err   <= 1'b0;
                        end
                    end else begin
                        waitCnt <= waitCnt + WW'(1);
                        // The last allowed busy cycle ended without an ack.
                        if (waitCnt == WAIT_LAST) begin
                            state <= IDLE;
                            if (state == BUSY_IF) begin
                                if_valid <= 1'b1;
                                if_rdata <= '0;
                                if_err   <= 1'b1;
                            end else begin
                                d_valid <= 1'b1;
                                d_rdata <= '0;
                                d_err   <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifReq = 1'b0, dReq = 1'b0, dWe = 1'b0, dUns = 1'b0;
    logic [31:0] ifAddr = '0, dAddr = '0, dWdata = '0;
    logic [1:0]  dSize = '0;
    logic        ifGnt, ifValid, ifErr, dGnt, dValid, dErr;
    logic [31:0] ifRdata, dRdata;
    logic        memReq, memWe, memUns, own;
    logic [1:0]  memSize;
    logic [31:0] memAddr, memWdata;
    logic        respAck = 1'b0, lateAck = 1'b0;
    logic [31:0] respData = '0;
    logic        memAck;
    assign memAck = respAck | lateAck;

    mem_port_arbiter #(.MAX_WAIT(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(ifReq), .if_addr(ifAddr), .if_gnt(ifGnt), .if_valid(ifValid),
        .if_rdata(ifRdata), .if_err(ifErr),
        .d_req(dReq), .d_we(dWe), .d_size(dSize), .d_unsigned(dUns),
        .d_addr(dAddr), .d_wdata(dWdata), .d_gnt(dGnt), .d_valid(dValid),
        .d_rdata(dRdata), .d_err(dErr),
        .mem_req(memReq), .mem_we(memWe), .mem_size(memSize),
        .mem_unsigned(memUns), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_ack(memAck), .mem_rdata(respData), .owner(own)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ackLat = -1;   // busy cycles before ack; -1 = never ack
    int busyCnt = 0;

    typedef struct {
        logic        isData;
        logic [31:0] rdata;
        logic        err;
    } expT;
    expT sb[$];
    logic gntKind[$];
    int   gntCyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic isData, input logic [31:0] rdata, input logic err);
        expT e;
        e.isData = isData; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    always @(posedge clk) cyc++;

    // Memory responder: acks after ackLat busy cycles.
    always @(posedge clk) begin
        #1;
        if (memReq) begin
            respAck = (ackLat >= 0 && busyCnt == ackLat);
            busyCnt++;
        end else begin
            respAck = 1'b0;
            busyCnt = 0;
        end
    end

    // Grant logger
    always @(negedge clk) begin
        if (dGnt)  begin gntKind.push_back(1'b1); gntCyc.push_back(cyc); end
        if (ifGnt) begin gntKind.push_back(1'b0); gntCyc.push_back(cyc); end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (ifValid || dValid) begin
            check("singleValid", {31'b0, ifValid & dValid}, 32'd0);
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpectedValid: got if_valid=%b d_valid=%b expected none (cycle %0d)",
                         ifValid, dValid, cyc);
            end else begin
                expT e;
                e = sb.pop_front();
                check("vldKind", {31'b0, dValid}, {31'b0, e.isData});
                check("vldRdata", dValid ? dRdata : ifRdata, e.rdata);
                check("vldErr", {31'b0, dValid ? dErr : ifErr}, {31'b0, e.err});
            end
        end
    end

    task automatic reqFetch(input logic [31:0] a);
        ifAddr = a; ifReq = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ifGnt) begin tick(); ifReq = 1'b0; return; end
        end
        check("fetchGntTimeout", 32'd0, 32'd1);
        ifReq = 1'b0;
    endtask

    task automatic reqData(input logic we, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] wd);
        dWe = we; dSize = sz; dUns = un; dAddr = a; dWdata = wd; dReq = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dGnt) begin tick(); dReq = 1'b0; return; end
        end
        check("dataGntTimeout", 32'd0, 32'd1);
        dReq = 1'b0;
    endtask

    // Counts negedges until a valid pulse; -1 on timeout.
    task automatic waitVld(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ifValid || dValid) begin n = i; return; end
        end
    endtask

    int n;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstGnt", {30'b0, ifGnt, dGnt}, 32'd0);
        check("rstMemReq", {31'b0, memReq}, 32'd0);
        check("rstValid", {30'b0, ifValid, dValid}, 32'd0);
        check("rstOwner", {31'b0, own}, 32'd0);
        check("rstMemAddr", memAddr, 32'd0);
        check("rstRdata", ifRdata | dRdata, 32'd0);
        tick(); rst = 1'b1; tick();

        // 1: single fetch with one wait state
        ackLat = 1; respData = 32'h2008_0005;
        push(1'b0, 32'h2008_0005, 1'b0);
        ifAddr = 32'h0000_3000; ifReq = 1'b1;
        @(negedge clk);
        check("t1Gnt", {30'b0, ifGnt, dGnt}, 32'd2);
        tick(); ifReq = 1'b0;
        @(negedge clk);
        check("t1MemReq", {31'b0, memReq}, 32'd1);
        check("t1MemAddr", memAddr, 32'h0000_3000);
        check("t1MemWe", {29'b0, memWe, memSize}, 32'd0);
        check("t1Owner", {31'b0, own}, 32'd0);
        waitVld(n);
        check("t1Latency", n, 32'd2);   // valid at T3: two negedges after T1
        repeat (2) tick();

        // 2: simultaneous requests, data first, fetch right after
        ackLat = 0; respData = 32'h1234_5678;
        gntKind.delete(); gntCyc.delete();
        push(1'b1, 32'h1234_5678, 1'b0);
        push(1'b0, 32'h1234_5678, 1'b0);
        fork
            reqData(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'd0);
            reqFetch(32'h0000_3004);
        join
        repeat (4) tick();
        check("t2NumGnt", gntKind.size(), 32'd2);
        if (gntKind.size() == 2) begin
            check("t2Order", {30'b0, gntKind[0], gntKind[1]}, 32'd2);
            check("t2Spacing", gntCyc[1] - gntCyc[0], 32'd2);
        end

        // 3: both held continuously -> DDDDI DDDDI
        ackLat = 0; respData = 32'hCAFE_0000;
        gntKind.delete(); gntCyc.delete();
        for (int k = 0; k < 10; k++) push((k % 5) != 4, 32'hCAFE_0000, 1'b0);
        dWe = 1'b0; dSize = 2'b00; dUns = 1'b0; dAddr = 32'h20; ifAddr = 32'h40;
        dReq = 1'b1; ifReq = 1'b1;
        for (int i = 0; i < 100 && gntKind.size() < 10; i++) @(negedge clk);
        tick(); dReq = 1'b0; ifReq = 1'b0;
        check("t3NumGnt", gntKind.size(), 32'd10);
        if (gntKind.size() == 10) begin
            logic [9:0] seq;
            for (int k = 0; k < 10; k++) seq[9-k] = gntKind[k];
            check("t3Pattern", {22'b0, seq}, {22'b0, 10'b11110_11110});
        end
        repeat (4) tick();

        // 4: store that times out, then a late ack
        ackLat = -1;
        push(1'b1, 32'd0, 1'b1);
        reqData(1'b1, 2'b01, 1'b0, 32'h0000_0013, 32'h0000_00A5);
        @(negedge clk);
        check("t4MemWe", {29'b0, memWe, memSize}, 32'b101);
        check("t4MemAddr", memAddr, 32'h0000_0013);
        check("t4MemWdata", memWdata, 32'h0000_00A5);
        n = 1;
        for (int i = 0; i < 40 && memReq; i++) begin @(negedge clk); if (memReq) n++; end
        check("t4BusyCycles", n, 32'd16);
        check("t4ErrValid", {30'b0, dValid, dErr}, 32'd3);
        check("t4MemReqDrop", {31'b0, memReq}, 32'd0);
        tick(); lateAck = 1'b1; tick(); lateAck = 1'b0;
        @(negedge clk);
        check("t4LateAckIgnored", {31'b0, memReq}, 32'd0);
        tick();

        // 5: reset in the middle of a data access
        ackLat = -1;
        reqData(1'b0, 2'b00, 1'b0, 32'h0000_0050, 32'd0);
        @(negedge clk);
        check("t5Busy", {31'b0, memReq}, 32'd1);
        tick(); rst = 1'b0;
        tick(); rst = 1'b1;
        @(negedge clk);
        check("t5MemReqOff", {31'b0, memReq}, 32'd0);
        check("t5NoValid", {31'b0, dValid}, 32'd0);
        ackLat = 0; respData = 32'h0BAD_F00D;
        push(1'b0, 32'h0BAD_F00D, 1'b0);
        tick(); ifAddr = 32'h0000_3008; ifReq = 1'b1;
        @(negedge clk);
        check("t5ImmediateGnt", {31'b0, ifGnt}, 32'd1);
        tick(); ifReq = 1'b0;
        repeat (4) tick();

        // 6: unsigned halfword load, zero wait states
        ackLat = 0; respData = 32'h0000_FFFE;
        push(1'b1, 32'h0000_FFFE, 1'b0);
        reqData(1'b0, 2'b10, 1'b1, 32'h0000_0022, 32'd0);
        @(negedge clk);
        check("t6MemFields", {28'b0, memWe, memSize, memUns}, 32'b0101);
        check("t6Owner", {31'b0, own}, 32'd1);
        waitVld(n);
        check("t6Latency", n, 32'd1);
        repeat (4) tick();

        check("sbDrained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
